// File: rtl/mips_reg_file_param_if.sv
// Bundle of write, read, HI/LO and clear-control signals for the register file.
//   master: datapath side, drives writes, read addresses, HI/LO data, clear_req
//   slave : register file side, returns rdata, hi_out, lo_out, clear_busy
interface mips_reg_file_param_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NUM_RD = 2
);
   logic                       we0;
   logic [ADDR_W-1:0]          waddr0;
   logic [DATA_W-1:0]          wdata0;
   logic                       we1;
   logic [ADDR_W-1:0]          waddr1;
   logic [DATA_W-1:0]          wdata1;
   logic [NUM_RD*ADDR_W-1:0]   raddr;
   logic [NUM_RD*DATA_W-1:0]   rdata;
   logic                       hilo_we;
   logic [DATA_W-1:0]          hi_in;
   logic [DATA_W-1:0]          lo_in;
   logic [DATA_W-1:0]          hi_out;
   logic [DATA_W-1:0]          lo_out;
   logic                       clear_req;
   logic                       clear_busy;

   modport master (
      output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr,
             hilo_we, hi_in, lo_in, clear_req,
      input  rdata, hi_out, lo_out, clear_busy
   );

   modport slave (
      input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr,
             hilo_we, hi_in, lo_in, clear_req,
      output rdata, hi_out, lo_out, clear_busy
   );
endinterface

// File: rtl/mips_reg_file_param.sv
// Parametrised MIPS register file: two write ports (port 1 wins on collision),
// NUM_RD combinational read ports with optional write-to-read bypass, a HI/LO
// pair, and a clear engine that zeroes one entry per cycle.
//   CLK   : clock, all state updates on posedge
//   reset : asynchronous, active-high
//   bus   : mips_reg_file_param_if slave modport (writes, reads, HI/LO, clear)
module mips_reg_file_param #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input logic                  CLK,
   input logic                  reset,
   mips_reg_file_param_if.slave bus
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   cnt;
   logic                busy;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   hi_q;
   logic [DATA_W-1:0]   lo_q;

   logic                wr0_c;
   logic                wr1_c;
   logic                byp_ok_c;
   logic [ADDR_W-1:0]   ra_c;
   logic [DATA_W-1:0]   rd_c;
   logic [NUM_RD*DATA_W-1:0] rdata_c;

   // Port enables with the hardwired-zero entry filtered out
   assign wr0_c = bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == '0));
   assign wr1_c = bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == '0));
   // Forwarding only for writes the array will actually accept this edge
   assign byp_ok_c = (BYPASS != 0) && !busy && !reset;

   // Array, HI/LO and clear sequencer
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         hi_q  <= '0;
         lo_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               // Port 1 assigned last so it wins an address collision
               if (wr0_c) mem[bus.waddr0] <= bus.wdata0;
               if (wr1_c) mem[bus.waddr1] <= bus.wdata1;
               if (bus.hilo_we) begin
                  hi_q <= bus.hi_in;
                  lo_q <= bus.lo_in;
               end
               if (bus.clear_req) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               mem[cnt] <= '0;
               if (cnt == '0) begin
                  hi_q <= '0;
                  lo_q <= '0;
               end
               if (cnt == ADDR_W'(DEPTH - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + ADDR_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Combinational read ports
   always_comb begin
      rdata_c = '0;
      ra_c    = '0;
      rd_c    = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         ra_c = bus.raddr[k*ADDR_W +: ADDR_W];
         rd_c = mem[ra_c];
         if (byp_ok_c && wr0_c && (bus.waddr0 == ra_c)) rd_c = bus.wdata0;
         if (byp_ok_c && wr1_c && (bus.waddr1 == ra_c)) rd_c = bus.wdata1;
         if ((ZERO_REG != 0) && (ra_c == '0)) rd_c = '0;
         rdata_c[k*DATA_W +: DATA_W] = rd_c;
      end
   end

   assign bus.rdata      = rdata_c;
   assign bus.hi_out     = hi_q;
   assign bus.lo_out     = lo_q;
   assign bus.clear_busy = busy;
endmodule
